// File: rtl/downcounter_tens.sv
// downcounter_tens: two-digit BCD down counter with load, wrap to lim_val and borrow out.
// Optional BOUT_ONE_PULSE_EN: registered one-cycle bout pulse after each wrap instead of combinational bout.
module downcounter_tens (
  input  logic       clk,
  input  logic       rst,
  input  logic       decrease,
  input  logic       load,
  input  logic [7:0] init_val,
  input  logic [7:0] lim_val,
  output logic [7:0] cnt,
  output logic       bout,
  output logic       zero,
  output logic       running
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nxt;
  logic [7:0] cnt_nxt;
  function automatic logic [7:0] clamp(input logic [7:0] v);
    return {v[7:4] > 4'd9 ? 4'd9 : v[7:4], v[3:0] > 4'd9 ? 4'd9 : v[3:0]};
  endfunction
  assign zero = cnt == 8'h00;
  assign running = state == RUN;
  always_comb begin
    state_nxt = load ? RUN : state;
    cnt_nxt = cnt;
    if (load) cnt_nxt = clamp(init_val);
    else if (running && decrease)
      cnt_nxt = zero ? clamp(lim_val)
              : cnt[3:0] != 4'd0 ? {cnt[7:4], cnt[3:0] - 4'd1}
              : {cnt[7:4] - 4'd1, 4'd9};
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      cnt <= 8'h00;
    end else begin
      state <= state_nxt;
      cnt <= cnt_nxt;
    end
  end
`ifdef BOUT_ONE_PULSE_EN
  logic bout_q;
  always_ff @(posedge clk) bout_q <= rst && running && decrease && !load && zero;
  assign bout = bout_q;
`else
  assign bout = running && zero && decrease;
`endif
endmodule

// File: tb/tb_downcounter_tens.sv
// tb_downcounter_tens: directed and random stimulus against a decimal-arithmetic reference model.
module tb_downcounter_tens;
  logic clk = 0;
  logic rst, decrease, load;
  logic [7:0] init_val, lim_val, cnt;
  logic bout, zero, running;
  int total = 0, bad = 0;
  int m_val = 0;
  bit m_run = 0, m_pulse = 0, m_valid = 0;

  downcounter_tens dut (
    .clk(clk), .rst(rst), .decrease(decrease), .load(load),
    .init_val(init_val), .lim_val(lim_val),
    .cnt(cnt), .bout(bout), .zero(zero), .running(running)
  );

  always #5 clk = ~clk;

  function automatic int clampdec(input logic [7:0] v);
    int t, o;
    t = int'(v[7:4]);
    o = int'(v[3:0]);
    if (t > 9) t = 9;
    if (o > 9) o = 9;
    return t * 10 + o;
  endfunction

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: count kept as a plain decimal number 0..99
  always @(posedge clk) begin
    m_pulse = 0;
    if (!rst) begin
      m_val = 0;
      m_run = 0;
      m_valid = 1;
    end else if (load) begin
      m_val = clampdec(init_val);
      m_run = 1;
    end else if (m_run && decrease) begin
      if (m_val == 0) begin
        m_val = clampdec(lim_val);
        m_pulse = 1;
      end else m_val = m_val - 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cnt", cnt, bcd(m_val));
      check("zero", {7'd0, zero}, {7'd0, m_val == 0});
      check("running", {7'd0, running}, {7'd0, m_run});
`ifdef BOUT_ONE_PULSE_EN
      check("bout", {7'd0, bout}, {7'd0, m_pulse});
`else
      check("bout", {7'd0, bout}, {7'd0, m_run && m_val == 0 && decrease});
`endif
    end
  end

  task automatic set(input logic r, input logic l, input logic d, input logic [7:0] iv, input logic [7:0] lv);
    rst = r; load = l; decrease = d; init_val = iv; lim_val = lv;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set(0, 0, 0, 8'h00, 8'h59);
    tick; tick;
    set(1, 0, 1, 8'h37, 8'h59);
    repeat (5) tick;
    check("idle_cnt", cnt, 8'h00);
    check("idle_run", {7'd0, running}, 8'h00);
    check("idle_zero", {7'd0, zero}, 8'h01);
    set(1, 1, 0, 8'h21, 8'h59); tick;
    check("load21", cnt, 8'h21);
    set(1, 0, 1, 8'h21, 8'h59); tick;
    check("dec20", cnt, 8'h20);
    tick;
    check("dec19", cnt, 8'h19);
    tick;
    check("dec18", cnt, 8'h18);
    check("run18", {7'd0, running}, 8'h01);
    set(1, 1, 0, 8'h01, 8'h59); tick;
    check("load01", cnt, 8'h01);
    set(1, 0, 1, 8'h01, 8'h59); #1;
    check("bout_at01", {7'd0, bout}, 8'h00);
    tick;
    check("dec00", cnt, 8'h00);
`ifdef BOUT_ONE_PULSE_EN
    check("bout_at00", {7'd0, bout}, 8'h00);
`else
    check("bout_at00", {7'd0, bout}, 8'h01);
`endif
    tick;
    check("wrap59", cnt, 8'h59);
`ifdef BOUT_ONE_PULSE_EN
    check("bout_after_wrap", {7'd0, bout}, 8'h01);
`else
    check("bout_after_wrap", {7'd0, bout}, 8'h00);
`endif
    tick;
    check("dec58", cnt, 8'h58);
    check("bout_58", {7'd0, bout}, 8'h00);
    set(1, 1, 0, 8'h35, 8'h59); tick;
    set(1, 1, 1, 8'h12, 8'h59); tick;
    check("load_over_dec", cnt, 8'h12);
    set(1, 1, 0, 8'hBC, 8'h59); tick;
    check("clamp_init", cnt, 8'h99);
    set(1, 1, 0, 8'h00, 8'h7F); tick;
    set(1, 0, 1, 8'h00, 8'h7F); tick;
    check("clamp_lim", cnt, 8'h79);
    set(1, 1, 0, 8'h00, 8'h00); tick;
    set(1, 0, 1, 8'h00, 8'h00); tick;
    check("wrap_lim00", cnt, 8'h00);
    tick;
    set(1, 1, 0, 8'h00, 8'h59); tick;
    set(0, 0, 1, 8'h00, 8'h59); tick;
    check("rst_mid_cnt", cnt, 8'h00);
    check("rst_mid_run", {7'd0, running}, 8'h00);
    set(1, 0, 1, 8'h00, 8'h59);
    repeat (3) begin
      tick;
      check("rst_mid_bout", {7'd0, bout}, 8'h00);
    end
    repeat (3000) begin
      set($urandom_range(0, 31) != 0, $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0,
          8'($urandom), $urandom_range(0, 5) == 0 ? 8'h00 : 8'($urandom));
      tick;
    end
    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/downcounter_tens.md
DOWNCOUNTER_TENS -- requirements
Module: downcounter_tens

Interface
REQ-001 The block SHALL have exactly one clock; reset SHALL be synchronous and active-low.
REQ-002 The port list SHALL be, clock and reset first:
- clk  input  1  global clock, all state updates on rising edge
- rst  input  1  synchronous active-low reset
- decrease  input  1  count-down request, sampled every cycle
- load  input  1  load init_val and arm the counter
- init_val  input  8  BCD start value: [7:4] tens, [3:0] ones
- lim_val  input  8  BCD wrap value loaded when counting below 00 (e.g. 8'h59)
- cnt  output  8  current BCD count: [7:4] tens, [3:0] ones
- bout  output  1  borrow out, for chaining to the next higher counter
- zero  output  1  high while cnt==8'h00
- running  output  1  high while the FSM is in RUN

Function
REQ-003 The FSM SHALL have two states, IDLE and RUN; running SHALL be 1 exactly in RUN.
REQ-004 The transition IDLE->RUN SHALL occur on any edge with load=1; there SHALL be no other exit from RUN except rst=0.
REQ-005 In IDLE, decrease SHALL be ignored and cnt SHALL hold.
REQ-006 Per-edge priority SHALL be rst, then load, then decrease.
REQ-007 With load=1, cnt SHALL take init_val at the next edge (latency 1), whether or not decrease is also 1.
REQ-008 In RUN with decrease=1, load=0 and cnt!=8'h00:
- if ones!=0: ones decrements and tens holds;
- if ones==0: ones becomes 9 and tens decrements.
REQ-009 In RUN with decrease=1, load=0 and cnt==8'h00, cnt SHALL take lim_val at the next edge; this is the "wrap event".
REQ-010 When init_val or lim_val is loaded into cnt, any digit greater than 9 SHALL be clamped to 9 (e.g. 8'hA7 loads as 8'h97).
REQ-011 cnt SHALL never hold a digit greater than 9.
REQ-012 zero SHALL be combinational, equal to (cnt==8'h00), in every state.
REQ-013 With decrease=0, or with the FSM in IDLE, cnt SHALL hold.
REQ-014 If lim_val==8'h00, a wrap event SHALL leave cnt at 00, and bout SHALL still follow REQ-019/REQ-020.
REQ-015 Loading init_val==8'h00 SHALL be legal: the first decrease after the load wraps to lim_val.

Reset
REQ-016 With rst=0 at an edge:
- the FSM SHALL go to IDLE;
- cnt SHALL become 8'h00;
- any registered bout state SHALL clear.
REQ-017 Reset SHALL take effect at the next edge even during a wrap or a load, overriding both.
REQ-018 Immediately after reset:
- zero=1 and running=0;
- bout SHALL be 0 when BOUT_ONE_PULSE_EN is defined, and 0 by REQ-020 (FSM in IDLE) otherwise.

Configuration
REQ-019 With macro BOUT_ONE_PULSE_EN defined, bout SHALL be a registered pulse:
- high for exactly one cycle, in the cycle after each wrap event;
- low at all other times;
- back-to-back wrap events SHALL give one pulse each.
REQ-020 Without BOUT_ONE_PULSE_EN, bout SHALL be combinational, equal to (running && cnt==8'h00 && decrease). It is then high in the same cycle that a wrap is requested, which allows same-cycle chaining into a higher stage's decrease.

Verification
REQ-021 Reset then IDLE: rst=0 for 2 cycles, then decrease=1 for 5 cycles -> cnt=8'h00, running=0, zero=1, no wrap.
REQ-022 Countdown across a tens boundary:
- stimulus: load with init_val=8'h21, then decrease=1 for 3 cycles;
- required: cnt sequence 21, 20, 19, 18; running=1.
REQ-023 Wrap, lim_val=8'h59:
- stimulus: load 8'h01, then decrease=1 for 3 cycles;
- required: cnt sequence 01, 00, 59, 58;
- with the macro: bout=1 for exactly the one cycle after the 00->59 edge;
- without the macro: bout=1 for exactly the cycle in which cnt==00 and decrease==1.
REQ-024 Simultaneous load and decrease: in RUN at cnt=8'h35, load=1 and decrease=1 with init_val=8'h12 -> next cnt=8'h12.
REQ-025 Clamp: load init_val=8'hBC -> cnt=8'h99; lim_val=8'h7F and a wrap from 00 -> cnt=8'h79.
REQ-026 Reset mid-operation: in RUN at cnt=8'h00 with decrease=1, rst=0 in the same cycle -> next cnt=8'h00, FSM in IDLE, and no bout pulse in any later cycle.
